// File: rtl/prs_checker_pkg.sv
// Shared PRS definitions: history width, feedback taps and checker FSM states.
// The generator uses the same taps, so both sides agree on the sequence.
package prs_checker_pkg;

    localparam int HIST_W = 32;

    // Taps at history bits 31, 30, 29, 27, 25 and 0
    localparam logic [HIST_W-1:0] PRS_TAPS = 32'hEA00_0001;

    typedef logic [1:0] state_t;
    localparam state_t ST_FILL   = 2'd0;
    localparam state_t ST_SEARCH = 2'd1;
    localparam state_t ST_LOCKED = 2'd2;

    function automatic logic prs_bit(input logic [HIST_W-1:0] hist);
        return ^(hist & PRS_TAPS);
    endfunction

endpackage

// File: rtl/prs_predict.sv
// Combinational next-bit prediction from the 32-bit PRS history.
module prs_predict
    import prs_checker_pkg::*;
(
    input  logic [HIST_W-1:0] hist_i,
    output logic              pred_o
);

    assign pred_o = prs_bit(hist_i);

endmodule

// File: rtl/prs_checker.sv
// PRS checker: fill / search / locked FSM with windowed loss-of-lock detection.
// Optional statistics counters are built only when PRS_CHECKER_STATS_EN is defined.
module prs_checker
    import prs_checker_pkg::*;
#(
    parameter int LOCK_CNT = 64,
    parameter int LOSS_WIN = 256,
    parameter int LOSS_THR = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int FILL_W  = $clog2(HIST_W + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(LOSS_WIN + 1);

    state_t              state_q, state_d;
    logic [HIST_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [WIN_W-1:0]    winBits_q, winBits_d;
    logic [WIN_W-1:0]    winErrs_q, winErrs_d;
    logic [WIN_W-1:0]    winErrsNext;
    logic                locked_q, errPulse_q;
    logic                pred, bitErr, lockedBit;

    prs_predict u_predict (
        .hist_i (hist_q),
        .pred_o (pred)
    );

    // Once locked the history free-runs on its own prediction, so a received
    // error is counted once instead of being multiplied through the taps.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_d     = match_q;
        winBits_d   = winBits_q;
        winErrs_d   = winErrs_q;
        winErrsNext = winErrs_q;
        bitErr      = 1'b0;
        lockedBit   = 1'b0;
        if (in_valid) begin
            case (state_q)
                ST_FILL: begin
                    hist_d = {in_bit, hist_q[HIST_W-1:1]};
                    if (fill_q == FILL_W'(HIST_W - 1)) begin
                        fill_d  = '0;
                        state_d = ST_SEARCH;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                ST_SEARCH: begin
                    hist_d = {in_bit, hist_q[HIST_W-1:1]};
                    if ((in_bit == pred) && (hist_q != '0)) begin
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            match_d   = '0;
                            winBits_d = '0;
                            winErrs_d = '0;
                            state_d   = ST_LOCKED;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    lockedBit   = 1'b1;
                    bitErr      = (in_bit != pred);
                    hist_d      = {pred, hist_q[HIST_W-1:1]};
                    winErrsNext = winErrs_q + WIN_W'(bitErr);
                    if (winBits_q == WIN_W'(LOSS_WIN - 1)) begin
                        winBits_d = '0;
                        winErrs_d = '0;
                        if (winErrsNext >= WIN_W'(LOSS_THR)) begin
                            fill_d  = '0;
                            match_d = '0;
                            state_d = ST_FILL;
                        end
                    end else begin
                        winBits_d = winBits_q + WIN_W'(1);
                        winErrs_d = winErrsNext;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FILL;
            hist_q     <= '0;
            fill_q     <= '0;
            match_q    <= '0;
            winBits_q  <= '0;
            winErrs_q  <= '0;
            locked_q   <= 1'b0;
            errPulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            match_q    <= match_d;
            winBits_q  <= winBits_d;
            winErrs_q  <= winErrs_d;
            locked_q   <= (state_d == ST_LOCKED);
            errPulse_q <= bitErr;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = errPulse_q;

`ifdef PRS_CHECKER_STATS_EN
    logic [CNT_W-1:0] bitCnt_q, errCnt_q;

    // Clear wins over a coincident increment; both counters saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitCnt_q <= '0;
            errCnt_q <= '0;
        end else if (clr) begin
            bitCnt_q <= '0;
            errCnt_q <= '0;
        end else begin
            if (lockedBit && (bitCnt_q != '1)) bitCnt_q <= bitCnt_q + CNT_W'(1);
            if (bitErr && (errCnt_q != '1))    errCnt_q <= errCnt_q + CNT_W'(1);
        end
    end

    assign bit_cnt = bitCnt_q;
    assign err_cnt = errCnt_q;
`else
    logic unusedStats;
    assign unusedStats = clr ^ lockedBit;
    assign bit_cnt     = '0;
    assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_prs_checker.sv
// Self-checking bench for prs_checker: reference model feeds a scoreboard queue,
// plus directed checks for lock timing, loss windows, clear and async reset.
module tb_prs_checker;
    import prs_checker_pkg::*;

    localparam int LOCK_CNT = 64;
    localparam int LOSS_WIN = 256;
    localparam int LOSS_THR = 16;
    localparam int CNT_W    = 8;
    localparam int MAXC     = (1 << CNT_W) - 1;
`ifdef PRS_CHECKER_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_bit;
    logic             clr;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] err_cnt;

    prs_checker #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_WIN (LOSS_WIN),
        .LOSS_THR (LOSS_THR),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .bit_cnt   (bit_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             lck;
        logic             errp;
        logic [CNT_W-1:0] bitc;
        logic [CNT_W-1:0] errc;
    } exp_t;

    exp_t        expQ[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] genState = 32'h974CA351;
    int          mState, mFill, mMatch, mWinBits, mWinErrs, mBitCnt, mErrCnt;
    logic [31:0] mHist;
    logic        mLocked, mErrp;
    logic        sawLock;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nextGen(output logic b);
        b = ^(genState & PRS_TAPS);
        genState = {b, genState[31:1]};
    endtask

    task automatic modelReset();
        mState = 0; mFill = 0; mMatch = 0; mWinBits = 0; mWinErrs = 0;
        mBitCnt = 0; mErrCnt = 0; mHist = '0; mLocked = 1'b0; mErrp = 1'b0;
    endtask

    // Behavioural reference: state as integers, history as a plain shift register
    task automatic modelStep(input logic v, input logic b, input logic c);
        logic p, e;
        e = 1'b0;
        if (v) begin
            p = ^(mHist & PRS_TAPS);
            if (mState == 0) begin
                mHist = {b, mHist[31:1]};
                mFill++;
                if (mFill == 32) begin mState = 1; mFill = 0; end
            end else if (mState == 1) begin
                if (b == p && mHist != 0) mMatch++; else mMatch = 0;
                mHist = {b, mHist[31:1]};
                if (mMatch == LOCK_CNT) begin
                    mState = 2; mMatch = 0; mWinBits = 0; mWinErrs = 0;
                end
            end else begin
                e = (b != p);
                mHist = {p, mHist[31:1]};
                if (STATS_EN) begin
                    if (mBitCnt < MAXC) mBitCnt++;
                    if (e && mErrCnt < MAXC) mErrCnt++;
                end
                mWinBits++;
                mWinErrs += int'(e);
                if (mWinBits == LOSS_WIN) begin
                    if (mWinErrs >= LOSS_THR) mState = 0;
                    mWinBits = 0;
                    mWinErrs = 0;
                end
            end
        end
        if (c) begin mBitCnt = 0; mErrCnt = 0; end
        mLocked = (mState == 2);
        mErrp = e;
    endtask

    task automatic checkOutput();
        exp_t e;
        e = expQ.pop_front();
        checkVal("locked", 32'(locked), 32'(e.lck));
        checkVal("err_pulse", 32'(err_pulse), 32'(e.errp));
        checkVal("bit_cnt", 32'(bit_cnt), 32'(e.bitc));
        checkVal("err_cnt", 32'(err_cnt), 32'(e.errc));
        sawLock |= locked;
    endtask

    task automatic applyStimulus(input logic v, input logic b, input logic c);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        clr      = c;
        modelStep(v, b, c);
        expQ.push_back('{mLocked, mErrp, CNT_W'(mBitCnt), CNT_W'(mErrCnt)});
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic sendGen(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            nextGen(b);
            applyStimulus(1'b1, b, 1'b0);
        end
    endtask

    task automatic sendErr(input int n, input logic c);
        logic b;
        for (int i = 0; i < n; i++) begin
            nextGen(b);
            applyStimulus(1'b1, ~b, c);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);
        checkVal("rst_locked", 32'(locked), 32'd0);
        checkVal("rst_err_pulse", 32'(err_pulse), 32'd0);
        checkVal("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        checkVal("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        modelReset();
        expQ.delete();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr = 1'b0;
        modelReset();

        $display("[TB] lock acquisition from seed");
        doReset();
        sendGen(95);
        checkVal("lock_at_95", 32'(locked), 32'd0);
        sendGen(1);
        checkVal("lock_at_96", 32'(locked), 32'd1);
        sendGen(4);
        checkVal("bit_cnt_100", 32'(bit_cnt), STATS_EN ? 32'd4 : 32'd0);
        checkVal("err_cnt_clean", 32'(err_cnt), 32'd0);

        $display("[TB] single inverted bit");
        sendErr(1, 1'b0);
        checkVal("one_err_pulse", 32'(err_pulse), 32'd1);
        checkVal("one_err_cnt", 32'(err_cnt), STATS_EN ? 32'd1 : 32'd0);
        sendGen(1);
        checkVal("one_err_pulse_end", 32'(err_pulse), 32'd0);
        checkVal("one_err_locked", 32'(locked), 32'd1);

        $display("[TB] loss-of-lock windows");
        doReset();
        sendGen(96);
        sendErr(15, 1'b0);
        sendGen(LOSS_WIN - 15);
        checkVal("win_15_locked", 32'(locked), 32'd1);
        sendErr(16, 1'b0);
        sendGen(LOSS_WIN - 17);
        checkVal("win_16_before_end", 32'(locked), 32'd1);
        sendGen(1);
        checkVal("win_16_lost", 32'(locked), 32'd0);
        checkVal("bit_cnt_sat", 32'(bit_cnt), STATS_EN ? 32'd255 : 32'd0);

        $display("[TB] clear coincident with error");
        doReset();
        sendGen(96);
        sendErr(1, 1'b0);
        sendErr(1, 1'b1);
        checkVal("clr_err_cnt", 32'(err_cnt), 32'd0);
        checkVal("clr_err_pulse", 32'(err_pulse), 32'd1);

        $display("[TB] gapped valid stream");
        doReset();
        for (int i = 0; i < 95; i++) begin
            sendGen(1);
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        checkVal("gap_lock_95", 32'(locked), 32'd0);
        sendGen(1);
        checkVal("gap_lock_96", 32'(locked), 32'd1);

        $display("[TB] async reset while locked");
        doReset();
        sendGen(96);
        sendErr(5, 1'b0);
        checkVal("pre_rst_err_cnt", 32'(err_cnt), STATS_EN ? 32'd5 : 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkVal("async_rst_locked", 32'(locked), 32'd0);
        checkVal("async_rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        expQ.delete();
        sendGen(95);
        checkVal("relock_95", 32'(locked), 32'd0);
        sendGen(1);
        checkVal("relock_96", 32'(locked), 32'd1);

        $display("[TB] all-zero input");
        doReset();
        sawLock = 1'b0;
        for (int i = 0; i < 1000; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkVal("zeros_never_lock", 32'(sawLock), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prs_checker.md
PRS_CHECKER -- requirements
Module: prs_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 64: consecutive matching bits needed to declare lock.
REQ-002 SHALL have parameter LOSS_WIN, default 256: bits per loss-of-lock evaluation window.
REQ-003 SHALL have parameter LOSS_THR, default 16: errors per window that force loss of lock.
REQ-004 SHALL have parameter CNT_W, default 32: statistics counter width.
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1: in_bit qualifier.
REQ-008 SHALL have port in_bit, input, 1: received PRS bit.
REQ-009 SHALL have port clr, input, 1: synchronous clear of statistics counters.
REQ-010 SHALL have port locked, output, 1: checker synchronised to the sequence.
REQ-011 SHALL have port err_pulse, output, 1: one-cycle pulse per bit error while locked.
REQ-012 SHALL have port bit_cnt, output, CNT_W: bits checked while locked.
REQ-013 SHALL have port err_cnt, output, CNT_W: errors counted while locked.

Function
REQ-014 SHALL keep 32-bit history hist; prediction p = hist[31]^hist[30]^hist[29]^hist[27]^hist[25]^hist[0]; update hist <= {b, hist[31:1]}, only on in_valid.
REQ-015 SHALL implement FSM FILL -> SEARCH -> LOCKED; ignore all inputs when in_valid=0 (gaps of any length change no state).
REQ-016 FILL: b = in_bit; after 32 valid bits -> SEARCH.
REQ-017 SEARCH: b = in_bit; match (in_bit==p) with hist!=0 increments match count; mismatch or hist==0 clears it; LOCK_CNT-th consecutive match -> LOCKED.
REQ-018 LOCKED: b = p (free-running, no error multiplication); error = in_bit!=p.
REQ-019 locked SHALL be registered, high from the cycle after the LOCK_CNT-th match until state leaves LOCKED.
REQ-020 err_pulse SHALL be registered, high exactly the cycle after an erroneous valid bit in LOCKED; never outside LOCKED.
REQ-021 LOCKED SHALL count valid bits and errors per window; at the LOSS_WIN-th bit, if window errors >= LOSS_THR -> FILL, else restart window; window errors include the closing bit.
REQ-022 Entering FILL from LOCKED SHALL clear match, fill and window counters; bit_cnt/err_cnt retained.
REQ-023 bit_cnt/err_cnt SHALL increment only on valid bits in LOCKED, saturating at all-ones.
REQ-024 clr SHALL zero bit_cnt/err_cnt next cycle; clr coincident with an increment gives 0.

Reset
REQ-025 rst SHALL force state FILL, hist=0, all internal counters 0, locked=0, err_pulse=0, bit_cnt=0, err_cnt=0.
REQ-026 rst mid-LOCKED SHALL drop locked immediately; relock requires 32+LOCK_CNT further valid bits.

Configuration
REQ-027 Macro PRS_CHECKER_STATS_EN defined: bit_cnt/err_cnt counters and clr per REQ-023/024.
REQ-028 Macro undefined: no counter flops; bit_cnt/err_cnt tied to 0; clr ignored; lock/loss/err_pulse behaviour unchanged.

Structure
REQ-029 Shared package SHALL hold the FSM state enum, the tap constant (bits 31,30,29,27,25,0) and history width 32, common with the generator.
REQ-030 Sub-module prs_predict (combinational 32-bit history -> p) SHALL be instantiated once.

Verification
REQ-031 Generator seed 32'h974CA351 driving in_bit, in_valid=1 -> locked rises the cycle after valid bit 96; err_pulse never; err_cnt=0; bit_cnt=N-96 after N bits.
REQ-032 Locked, one bit inverted -> exactly one err_pulse, err_cnt=1, locked stays 1.
REQ-033 in_bit constant 0 for 1000 valid bits -> locked never asserts.
REQ-034 Locked, 16 errors within one 256-bit window -> locked drops the cycle after the window's 256th bit; 15 errors -> stays locked.
REQ-035 clr coincident with an error bit -> err_cnt=0, err_pulse still pulses; in_valid toggling 1/0 -> lock after 96 valid bits.
REQ-036 rst asserted mid-LOCKED with err_cnt=5 -> locked=0, err_cnt=0 immediately; relock after 96 further valid bits.
